// File: rtl/block_ram_dual_be.sv
// block_ram_dual_be: true dual-port RAM with byte enables, selectable read-during-write,
// optional output register and a post-reset clear engine.
module block_ram_dual_be #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter INIT_FILE = "UNUSED"
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [DATA_WIDTH-1:0]   DI_A,
    input  logic [ADDR_WIDTH-1:0]   ADDR_A,
    input  logic [DATA_WIDTH/8-1:0] BE_A,
    output logic [DATA_WIDTH-1:0]   DO_A,
    input  logic [DATA_WIDTH-1:0]   DI_B,
    input  logic [ADDR_WIDTH-1:0]   ADDR_B,
    input  logic [DATA_WIDTH/8-1:0] BE_B,
    output logic [DATA_WIDTH-1:0]   DO_B,
    output logic                    BUSY
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                  r_state, w_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_do_a, r_do_b, r_pipe_a, r_pipe_b;
    logic [DATA_WIDTH-1:0]   w_old_a, w_old_b, w_own_a, w_own_b, w_wr_a;
    logic                    w_busy;

    function automatic logic [DATA_WIDTH-1:0] f_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                      input logic [DATA_WIDTH-1:0] new_w,
                                                      input logic [NB-1:0] be);
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++)
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        return res;
    endfunction

    assign w_busy  = RESET | (r_state == S_CLEAR);
    assign BUSY    = w_busy;
    assign w_old_a = r_mem[ADDR_A];
    assign w_old_b = r_mem[ADDR_B];
    assign w_own_a = f_merge(w_old_a, DI_A, BE_A);
    assign w_own_b = f_merge(w_old_b, DI_B, BE_B);
    // On a shared address, A's word is built on top of B's so A wins its enabled lanes.
    assign w_wr_a  = f_merge(ADDR_A == ADDR_B ? w_own_b : w_old_a, DI_A, BE_A);
    assign DO_A    = OUT_REG != 0 ? r_pipe_a : r_do_a;
    assign DO_B    = OUT_REG != 0 ? r_pipe_b : r_do_b;

    always_comb begin
        w_next = r_state;
        if (RESET)
            w_next = CLEAR_ON_RESET != 0 ? S_CLEAR : S_IDLE;
        else if (r_state == S_CLEAR && r_cnt == LAST)
            w_next = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        r_state <= w_next;
        if (RESET)
            r_cnt <= '0;
        else if (r_state == S_CLEAR)
            r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (r_state == S_CLEAR)
                r_mem[r_cnt] <= CLEAR_VALUE;
            else begin
                if (|BE_B) r_mem[ADDR_B] <= w_own_b;
                if (|BE_A) r_mem[ADDR_A] <= w_wr_a;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_do_a   <= '0;
            r_do_b   <= '0;
            r_pipe_a <= '0;
            r_pipe_b <= '0;
        end else if (!w_busy) begin
            r_do_a   <= RDW_MODE != 0 ? w_old_a : w_own_a;
            r_do_b   <= RDW_MODE != 0 ? w_old_b : w_own_b;
            r_pipe_a <= r_do_a;
            r_pipe_b <= r_do_b;
        end
    end
endmodule

// File: tb/tb_block_ram_dual_be.sv
// tb_block_ram_dual_be: three configurations share one random/directed stimulus stream;
// a byte-level reference model feeds a scoreboard checked by an independent monitor.
module tb_block_ram_dual_be;
    localparam logic [31:0] CV = 32'hDEADBEEF;

    typedef struct packed {
        int              edge_n;
        logic [2:0]      busy, ka, kb;
        logic [2:0][31:0] da, db;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] di_a, di_b;
    logic [3:0]  ad_a, ad_b, be_a, be_b;
    logic [31:0] do_a [3];
    logic [31:0] do_b [3];
    logic [2:0]  busy;

    block_ram_dual_be #(.RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u0 (
        .CLK(clk), .RESET(rst), .DI_A(di_a), .ADDR_A(ad_a), .BE_A(be_a), .DO_A(do_a[0]),
        .DI_B(di_b), .ADDR_B(ad_b), .BE_B(be_b), .DO_B(do_b[0]), .BUSY(busy[0]));
    block_ram_dual_be #(.RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u1 (
        .CLK(clk), .RESET(rst), .DI_A(di_a), .ADDR_A(ad_a), .BE_A(be_a), .DO_A(do_a[1]),
        .DI_B(di_b), .ADDR_B(ad_b), .BE_B(be_b), .DO_B(do_b[1]), .BUSY(busy[1]));
    block_ram_dual_be #(.RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(0), .CLEAR_VALUE(CV)) u2 (
        .CLK(clk), .RESET(rst), .DI_A(di_a), .ADDR_A(ad_a), .BE_A(be_a), .DO_A(do_a[2]),
        .DI_B(di_b), .ADDR_B(ad_b), .BE_B(be_b), .DO_B(do_b[2]), .BUSY(busy[2]));

    bit rdw_c [3] = '{1'b0, 1'b1, 1'b0};
    bit oreg_c [3] = '{1'b0, 1'b1, 1'b0};
    bit cor_c [3] = '{1'b1, 1'b1, 1'b0};

    logic [31:0] m_mem [3][16];
    bit          m_kn [3][16];
    bit          m_clr [3];
    int          m_cnt [3];
    logic [31:0] m_do [3][2];
    logic [31:0] m_pp [3][2];
    bit          k_do [3][2];
    bit          k_pp [3][2];

    exp_t q[$];
    int checks = 0, fails = 0, n_edge = 0, m_edge = 0;

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int l = 0; l < 4; l++)
            if (be[l]) r[8*l +: 8] = d[8*l +: 8];
        return r;
    endfunction

    // Reference: what each configuration must show after the coming clock edge.
    task automatic step();
        exp_t e;
        logic [31:0] oa, ob;
        bit ka, kb;
        n_edge++;
        e = '0;
        e.edge_n = n_edge;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_clr[i] = cor_c[i];
                m_cnt[i] = 0;
                for (int p = 0; p < 2; p++) begin
                    m_do[i][p] = 32'h0; k_do[i][p] = 1'b1;
                    m_pp[i][p] = 32'h0; k_pp[i][p] = 1'b1;
                end
            end else if (m_clr[i]) begin
                m_mem[i][m_cnt[i]] = CV;
                m_kn[i][m_cnt[i]] = 1'b1;
                m_clr[i] = (m_cnt[i] != 15);
                m_cnt[i]++;
            end else begin
                oa = m_mem[i][ad_a]; ka = m_kn[i][ad_a];
                ob = m_mem[i][ad_b]; kb = m_kn[i][ad_b];
                for (int p = 0; p < 2; p++) begin
                    m_pp[i][p] = m_do[i][p]; k_pp[i][p] = k_do[i][p];
                end
                m_do[i][0] = rdw_c[i] ? oa : mrg(oa, di_a, be_a);
                k_do[i][0] = ka || (!rdw_c[i] && be_a == 4'hF);
                m_do[i][1] = rdw_c[i] ? ob : mrg(ob, di_b, be_b);
                k_do[i][1] = kb || (!rdw_c[i] && be_b == 4'hF);
                if (be_b != 0) begin
                    m_mem[i][ad_b] = mrg(ob, di_b, be_b);
                    m_kn[i][ad_b] = kb || be_b == 4'hF;
                end
                if (be_a != 0) begin
                    m_kn[i][ad_a] = m_kn[i][ad_a] || be_a == 4'hF;
                    m_mem[i][ad_a] = mrg(m_mem[i][ad_a], di_a, be_a);
                end
            end
            e.busy[i] = rst || m_clr[i];
            e.da[i] = oreg_c[i] ? m_pp[i][0] : m_do[i][0];
            e.ka[i] = oreg_c[i] ? k_pp[i][0] : k_do[i][0];
            e.db[i] = oreg_c[i] ? m_pp[i][1] : m_do[i][1];
            e.kb[i] = oreg_c[i] ? k_pp[i][1] : k_do[i][1];
        end
        q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [3:0] aa, input logic [31:0] da, input logic [3:0] ba,
                         input logic [3:0] ab, input logic [31:0] db, input logic [3:0] bb);
        rst = r; ad_a = aa; di_a = da; be_a = ba; ad_b = ab; di_b = db; be_b = bb;
        step();
    endtask

    task automatic tick(input logic r, input logic [3:0] aa, input logic [31:0] da, input logic [3:0] ba,
                        input logic [3:0] ab, input logic [31:0] db, input logic [3:0] bb);
        @(negedge clk);
        drive(r, aa, da, ba, ab, db, bb);
    endtask

    task automatic rd(input logic [3:0] aa, input logic [3:0] ab);
        tick(1'b0, aa, $urandom, 4'h0, ab, $urandom, 4'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge %0d: got %h expected %h", name, m_edge, act, exp);
        end
    endtask

    initial forever begin
        exp_t e;
        @(posedge clk);
        m_edge++;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("edge_align", m_edge, e.edge_n);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_busy", i), {31'b0, busy[i]}, {31'b0, e.busy[i]});
                if (e.ka[i]) chk($sformatf("u%0d_do_a", i), do_a[i], e.da[i]);
                if (e.kb[i]) chk($sformatf("u%0d_do_b", i), do_b[i], e.db[i]);
            end
        end
    end

    initial begin
        logic [3:0] aa, ab;
        int wait_cnt;
        drive(1'b1, 4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);
        repeat (2) tick(1'b1, 4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);
        repeat (16) tick(1'b0, 4'($urandom), $urandom, 4'hF, 4'($urandom), $urandom, 4'hF);
        for (int a = 0; a < 16; a++) rd(4'(a), 4'(15 - a));
        tick(1'b0, 4'd3, 32'h11223344, 4'hF, 4'd9, 32'h0, 4'h0);
        tick(1'b0, 4'd3, 32'hAABBCCDD, 4'b0101, 4'd3, 32'h0, 4'h0);
        rd(4'd3, 4'd3);
        rd(4'd3, 4'd3);
        tick(1'b0, 4'd7, 32'h000000FF, 4'b0001, 4'd7, 32'h12345678, 4'hF);
        rd(4'd7, 4'd7);
        tick(1'b0, 4'd7, 32'h0, 4'hF, 4'd7, 32'h0, 4'h0);
        rd(4'd7, 4'd7);
        rd(4'd7, 4'd7);
        tick(1'b0, 4'd0, 32'h0, 4'h0, 4'd2, 32'hCAFEF00D, 4'hF);
        rd(4'd0, 4'd2);
        rd(4'd0, 4'd3);
        rd(4'd0, 4'd2);
        rd(4'd0, 4'd0);
        repeat (3) tick(1'b1, 4'h0, 32'h0, 4'h0, 4'h0, 32'h0, 4'h0);
        repeat (8) rd(4'($urandom), 4'($urandom));
        tick(1'b1, 4'h0, 32'h0, 4'hF, 4'h0, 32'h0, 4'hF);
        repeat (16) tick(1'b0, 4'($urandom), $urandom, 4'hF, 4'($urandom), $urandom, 4'hF);
        for (int a = 0; a < 16; a++) rd(4'(a), 4'(a ^ 5));
        repeat (400) begin
            aa = 4'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? aa : 4'($urandom);
            tick(($urandom_range(0, 99) == 0), aa, $urandom,
                 ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
                 ab, $urandom, ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom));
        end
        repeat (20) rd(4'h0, 4'h0);
        for (int a = 0; a < 16; a++) rd(4'(a), 4'(15 - a));
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
